// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: ID-stage operand/destination info in, pipeline
// enables, flushes, retire strobe and event counters out.
interface hazard_ctrl_if;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned CNT_W  = 32;

   logic              i_id_vld;
   logic [REG_AW-1:0] i_id_rs1_addr;
   logic [REG_AW-1:0] i_id_rs2_addr;
   logic              i_id_rs1_use;
   logic              i_id_rs2_use;
   logic [REG_AW-1:0] i_id_rd_addr;
   logic              i_id_rd_wren;
   logic              i_ex_redirect;

   logic              o_pc_en;
   logic              o_pc_sel;
   logic              o_ifid_en;
   logic              o_ifid_flush;
   logic              o_idex_flush;
   logic              o_insn_vld;
   logic [CNT_W-1:0]  o_stall_cnt;
   logic [CNT_W-1:0]  o_flush_cnt;

   modport master (
      output i_id_vld, i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_use, i_id_rs2_use,
             i_id_rd_addr, i_id_rd_wren, i_ex_redirect,
      input  o_pc_en, o_pc_sel, o_ifid_en, o_ifid_flush, o_idex_flush,
             o_insn_vld, o_stall_cnt, o_flush_cnt
   );

   modport slave (
      input  i_id_vld, i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_use, i_id_rs2_use,
             i_id_rd_addr, i_id_rd_wren, i_ex_redirect,
      output o_pc_en, o_pc_sel, o_ifid_en, o_ifid_flush, o_idex_flush,
             o_insn_vld, o_stall_cnt, o_flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// In-order 5-stage pipeline hazard controller: RAW scoreboard over EX/MEM(/WB),
// stall/redirect steering of PC and IF/ID, and stall/redirect event counters.
module hazard_ctrl #(
   parameter bit WB_BYPASS = 1'b1
) (
   input  logic         i_clk,
   input  logic         i_rstn,
   hazard_ctrl_if.slave bus
);
   localparam int unsigned REG_AW = 5;
   localparam int unsigned CNT_W  = 32;

   typedef struct packed {
      logic              vld;
      logic [REG_AW-1:0] rd;
   } slot_t;

   slot_t            ex_slot, mem_slot, wb_slot;
   logic             ex_v, mem_v, wb_v;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   logic rs1_hit, rs2_hit, hazard, stall, issue;

   function automatic logic slot_hit(input slot_t s, input logic [REG_AW-1:0] rs);
      return s.vld && (s.rd == rs);
   endfunction

   // WB is only compared when the regfile cannot forward a same-cycle write
   always_comb begin
      rs1_hit = bus.i_id_rs1_use && (bus.i_id_rs1_addr != '0) &&
                (slot_hit(ex_slot, bus.i_id_rs1_addr) || slot_hit(mem_slot, bus.i_id_rs1_addr) ||
                 (!WB_BYPASS && slot_hit(wb_slot, bus.i_id_rs1_addr)));
      rs2_hit = bus.i_id_rs2_use && (bus.i_id_rs2_addr != '0) &&
                (slot_hit(ex_slot, bus.i_id_rs2_addr) || slot_hit(mem_slot, bus.i_id_rs2_addr) ||
                 (!WB_BYPASS && slot_hit(wb_slot, bus.i_id_rs2_addr)));
      hazard  = bus.i_id_vld && (rs1_hit || rs2_hit);
      stall   = hazard && !bus.i_ex_redirect;
      issue   = !hazard && !bus.i_ex_redirect;
   end

   // Pipeline steering; redirect outranks a pending stall
   always_comb begin
      bus.o_pc_en      = 1'b1;
      bus.o_pc_sel     = 1'b0;
      bus.o_ifid_en    = 1'b1;
      bus.o_ifid_flush = 1'b0;
      bus.o_idex_flush = 1'b0;
      if (bus.i_ex_redirect) begin
         bus.o_pc_sel     = 1'b1;
         bus.o_ifid_flush = 1'b1;
         bus.o_idex_flush = 1'b1;
      end else if (hazard) begin
         bus.o_pc_en      = 1'b0;
         bus.o_ifid_en    = 1'b0;
         bus.o_idex_flush = 1'b1;
      end
   end

   // Scoreboard shift; a stalled or flushed ID slot enters EX as a bubble
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         ex_slot  <= '0;
         mem_slot <= '0;
         wb_slot  <= '0;
         ex_v     <= 1'b0;
         mem_v    <= 1'b0;
         wb_v     <= 1'b0;
      end else begin
         wb_slot  <= mem_slot;
         mem_slot <= ex_slot;
         wb_v     <= mem_v;
         mem_v    <= ex_v;
         if (issue) begin
            ex_slot.vld <= bus.i_id_vld && bus.i_id_rd_wren && (bus.i_id_rd_addr != '0);
            ex_slot.rd  <= bus.i_id_rd_addr;
            ex_v        <= bus.i_id_vld;
         end else begin
            ex_slot <= '0;
            ex_v    <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall)             stall_cnt <= stall_cnt + CNT_W'(1);
         if (bus.i_ex_redirect) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

   assign bus.o_insn_vld  = wb_v;
   assign bus.o_stall_cnt = stall_cnt;
   assign bus.o_flush_cnt = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: dependence-distance stalls, redirects, reset release,
// counter wrap, and a WB_BYPASS=0 instance; retire strobes checked by scoreboard.
module tb_hazard_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   stall_total = 0;
   int   retire_q[$];

   hazard_ctrl_if hif ();
   hazard_ctrl_if hif_nb ();

   hazard_ctrl #(.WB_BYPASS(1'b1)) dut (.i_clk(clk), .i_rstn(rst_n), .bus(hif));
   hazard_ctrl #(.WB_BYPASS(1'b0)) dut_nb (.i_clk(clk), .i_rstn(rst_n), .bus(hif_nb));

   assign hif_nb.i_id_rs1_addr = hif.i_id_rs1_addr;
   assign hif_nb.i_id_rs2_addr = hif.i_id_rs2_addr;
   assign hif_nb.i_id_rs1_use  = hif.i_id_rs1_use;
   assign hif_nb.i_id_rs2_use  = hif.i_id_rs2_use;
   assign hif_nb.i_id_rd_addr  = hif.i_id_rd_addr;
   assign hif_nb.i_id_rd_wren  = hif.i_id_rd_wren;
   assign hif_nb.i_ex_redirect = hif.i_ex_redirect;

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Negedge sample point; also retires scoreboard entries due this cycle
   task automatic sample();
      bit exp_r;
      @(negedge clk);
      if (rst_n) begin
         exp_r = (retire_q.size() > 0) && (retire_q[0] == cyc);
         if (exp_r) void'(retire_q.pop_front());
         check("insn_vld", 32'(hif.o_insn_vld), 32'(exp_r));
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic idle();
      hif.i_id_vld      = 1'b0;
      hif_nb.i_id_vld   = 1'b0;
      hif.i_id_rs1_addr = '0;
      hif.i_id_rs2_addr = '0;
      hif.i_id_rs1_use  = 1'b0;
      hif.i_id_rs2_use  = 1'b0;
      hif.i_id_rd_addr  = '0;
      hif.i_id_rd_wren  = 1'b0;
      hif.i_ex_redirect = 1'b0;
   endtask

   // Present one instruction in ID and expect it to stall exactly exp_st cycles
   task automatic issue(input bit nb, input logic [4:0] rs1, input bit u1,
                        input logic [4:0] rs2, input bit u2, input logic [4:0] rd,
                        input bit wr, input int exp_st, input string tag);
      logic pe, fl, ie;
      hif.i_id_rs1_addr = rs1;
      hif.i_id_rs1_use  = u1;
      hif.i_id_rs2_addr = rs2;
      hif.i_id_rs2_use  = u2;
      hif.i_id_rd_addr  = rd;
      hif.i_id_rd_wren  = wr;
      if (nb) hif_nb.i_id_vld = 1'b1;
      else begin
         hif.i_id_vld = 1'b1;
         retire_q.push_back(cyc + exp_st + 3);
         stall_total += exp_st;
      end
      for (int k = 0; k <= exp_st; k++) begin
         sample();
         pe = nb ? hif_nb.o_pc_en      : hif.o_pc_en;
         fl = nb ? hif_nb.o_idex_flush : hif.o_idex_flush;
         ie = nb ? hif_nb.o_ifid_en    : hif.o_ifid_en;
         check({tag, "_pc_en"},      32'(pe), 32'(k == exp_st));
         check({tag, "_ifid_en"},    32'(ie), 32'(k == exp_st));
         check({tag, "_idex_flush"}, 32'(fl), 32'(k != exp_st));
         cycle();
      end
      idle();
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      #2;
      check("rst_insn_vld",   32'(hif.o_insn_vld),   32'(0));
      check("rst_stall_cnt",  hif.o_stall_cnt,       32'(0));
      check("rst_flush_cnt",  hif.o_flush_cnt,       32'(0));
      check("rst_pc_en",      32'(hif.o_pc_en),      32'(1));
      check("rst_ifid_en",    32'(hif.o_ifid_en),    32'(1));
      check("rst_pc_sel",     32'(hif.o_pc_sel),     32'(0));
      check("rst_ifid_flush", 32'(hif.o_ifid_flush), 32'(0));
      check("rst_idex_flush", 32'(hif.o_idex_flush), 32'(0));
      sample();
      rst_n = 1'b1;
      cycle();

      // distance 1: addi x5 ; add x6,x5,x0
      issue(0, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, "d1_prod");
      issue(0, 5'd5, 1, 5'd0, 1, 5'd6, 1, 2, "d1_cons");
      check("d1_stall_cnt", hif.o_stall_cnt, 32'(stall_total));

      // distance 2 via rs2
      issue(0, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0, "d2_prod");
      issue(0, 5'd1, 0, 5'd2, 0, 5'd8, 1, 0, "d2_mid");
      issue(0, 5'd3, 1, 5'd7, 1, 5'd9, 1, 1, "d2_cons");
      check("d2_stall_cnt", hif.o_stall_cnt, 32'(stall_total));

      // x0 and unused operands never stall
      issue(0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, "x0_prod");
      issue(0, 5'd0, 1, 5'd0, 1, 5'd4, 1, 0, "x0_cons");
      issue(0, 5'd0, 0, 5'd0, 0, 5'd9, 1, 0, "nu_prod");
      issue(0, 5'd9, 0, 5'd9, 0, 5'd4, 1, 0, "nu_cons");

      // invalid ID slot reading a pending rd must not stall
      issue(0, 5'd0, 0, 5'd0, 0, 5'd11, 1, 0, "iv_prod");
      hif.i_id_rs1_addr = 5'd11;
      hif.i_id_rs1_use  = 1'b1;
      sample();
      check("iv_pc_en", 32'(hif.o_pc_en), 32'(1));
      cycle();
      idle();
      check("nostall_cnt", hif.o_stall_cnt, 32'(stall_total));

      // redirect while a hazard is present
      issue(0, 5'd0, 0, 5'd0, 0, 5'd10, 1, 0, "rd_prod");
      hif.i_id_vld      = 1'b1;
      hif.i_id_rs1_addr = 5'd10;
      hif.i_id_rs1_use  = 1'b1;
      hif.i_ex_redirect = 1'b1;
      sample();
      check("redir_pc_sel",     32'(hif.o_pc_sel),     32'(1));
      check("redir_pc_en",      32'(hif.o_pc_en),      32'(1));
      check("redir_ifid_en",    32'(hif.o_ifid_en),    32'(1));
      check("redir_ifid_flush", 32'(hif.o_ifid_flush), 32'(1));
      check("redir_idex_flush", 32'(hif.o_idex_flush), 32'(1));
      cycle();
      idle();
      check("redir_flush_cnt", hif.o_flush_cnt, 32'(1));
      check("redir_stall_cnt", hif.o_stall_cnt, 32'(stall_total));
      for (int i = 0; i < 4; i++) begin sample(); cycle(); end

      // reset asserted in the second stall cycle
      issue(0, 5'd0, 0, 5'd0, 0, 5'd12, 1, 0, "mr_prod");
      hif.i_id_vld      = 1'b1;
      hif.i_id_rs1_addr = 5'd12;
      hif.i_id_rs1_use  = 1'b1;
      sample();
      check("mr_stall1_pc_en", 32'(hif.o_pc_en), 32'(0));
      cycle();
      rst_n = 1'b0;
      retire_q.delete();
      stall_total = 0;
      #1;
      check("mr_pc_en",      32'(hif.o_pc_en),      32'(1));
      check("mr_idex_flush", 32'(hif.o_idex_flush), 32'(0));
      check("mr_stall_cnt",  hif.o_stall_cnt,       32'(0));
      check("mr_flush_cnt",  hif.o_flush_cnt,       32'(0));
      check("mr_insn_vld",   32'(hif.o_insn_vld),   32'(0));
      idle();
      sample();
      rst_n = 1'b1;
      cycle();
      issue(0, 5'd12, 1, 5'd0, 0, 5'd13, 1, 0, "mr_cons");

      // counter wrap from all-ones on a single stall
      force dut.stall_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.stall_cnt;
      check("wrap_preload", hif.o_stall_cnt, 32'hFFFF_FFFF);
      issue(0, 5'd0, 0, 5'd0, 0, 5'd14, 1, 0, "wr_prod");
      issue(0, 5'd0, 0, 5'd0, 0, 5'd15, 1, 0, "wr_mid");
      issue(0, 5'd0, 0, 5'd14, 1, 5'd16, 1, 1, "wr_cons");
      check("wrap_stall_cnt", hif.o_stall_cnt, 32'h0000_0000);
      for (int i = 0; i < 4; i++) begin sample(); cycle(); end

      // no write-through: one extra stall cycle per distance
      issue(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0, "nb_d2_prod");
      issue(1, 5'd1, 0, 5'd2, 0, 5'd8, 1, 0, "nb_d2_mid");
      issue(1, 5'd7, 1, 5'd0, 0, 5'd9, 1, 2, "nb_d2_cons");
      for (int i = 0; i < 4; i++) begin sample(); cycle(); end
      issue(1, 5'd0, 0, 5'd0, 0, 5'd17, 1, 0, "nb_d1_prod");
      issue(1, 5'd0, 0, 5'd17, 1, 5'd18, 1, 3, "nb_d1_cons");
      check("nb_stall_cnt", hif_nb.o_stall_cnt, 32'(5));

      for (int i = 0; i < 5; i++) begin sample(); cycle(); end
      check("retire_q_empty", 32'(retire_q.size()), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter WB_BYPASS, default 1, meaning 1 = regfile writes through to same-cycle reads, so the WB slot is excluded from the hazard compare.
REQ-002 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port i_rstn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_id_vld  input  1  ID stage holds a valid instruction.
REQ-005 SHALL have port i_id_rs1_addr  input  5  ID source register 1.
REQ-006 SHALL have port i_id_rs2_addr  input  5  ID source register 2.
REQ-007 SHALL have port i_id_rs1_use / i_id_rs2_use  input  1 each  source operand actually read.
REQ-008 SHALL have port i_id_rd_addr  input  5  ID destination register.
REQ-009 SHALL have port i_id_rd_wren  input  1  ID instruction writes rd.
REQ-010 SHALL have port i_ex_redirect  input  1  EX resolved taken branch/jump.
REQ-011 SHALL have port o_pc_en  output  1  PC register enable.
REQ-012 SHALL have port o_pc_sel  output  1  1 = PC loads EX target, 0 = PC+4.
REQ-013 SHALL have port o_ifid_en  output  1  IF/ID register enable.
REQ-014 SHALL have port o_ifid_flush / o_idex_flush  output  1 each  insert bubble into IF/ID / ID/EX.
REQ-015 SHALL have port o_insn_vld  output  1  WB stage retires a valid instruction.
REQ-016 SHALL have port o_stall_cnt / o_flush_cnt  output  32 each  stall-cycle / redirect-event counters.

Function
REQ-017 SHALL keep scoreboard slots EX, MEM, WB, each {vld, rd[4:0]}, plus valid bits ex_v, mem_v, wb_v.
REQ-018 SHALL set slot vld only when the instruction writes rd and rd != 0.
REQ-019 SHALL compute hazard = i_id_vld AND ((rs1_use AND rs1 != 0 AND rs1 matches a valid compared slot) OR same for rs2). Compared slots are EX and MEM, plus WB when WB_BYPASS = 0.
REQ-020 SHALL, when i_ex_redirect = 1 (redirect priority over hazard), drive o_pc_en = 1, o_pc_sel = 1, o_ifid_en = 1, o_ifid_flush = 1, o_idex_flush = 1.
REQ-021 SHALL, when hazard = 1 and no redirect (stall), drive o_pc_en = 0, o_ifid_en = 0, o_idex_flush = 1, o_ifid_flush = 0, o_pc_sel = 0.
REQ-022 SHALL otherwise drive o_pc_en = 1, o_ifid_en = 1, all flushes 0, o_pc_sel = 0.
REQ-023 SHALL advance every cycle: WB<=MEM, MEM<=EX, wb_v<=mem_v, mem_v<=ex_v; the redirecting instruction itself still advances so JAL/JALR retire.
REQ-024 SHALL load EX slot <= {i_id_rd_wren AND rd!=0, i_id_rd_addr} and ex_v <= i_id_vld when ID issues (no stall, no redirect); otherwise EX slot vld <= 0 and ex_v <= 0 (bubble).
REQ-025 SHALL drive o_insn_vld = wb_v, registered; latency ID issue -> o_insn_vld = 3 cycles.
REQ-026 SHALL increment o_stall_cnt by 1 per stall cycle and o_flush_cnt by 1 per redirect cycle; both wrap 0xFFFFFFFF -> 0.
REQ-027 SHALL resolve hazards within a dependence distance of 1 with a 2-cycle stall and distance 2 with a 1-cycle stall (WB_BYPASS = 1); WB_BYPASS = 0 adds one stall cycle to each.
REQ-028 SHALL never stall on rs = x0, on unused operands, or when i_id_vld = 0.
REQ-029 SHALL keep o_pc_en, o_ifid_en, o_pc_sel and the flushes combinational from current state and inputs, glitch-irrelevant at the clock edge.

Reset
REQ-030 SHALL, on i_rstn = 0, asynchronously clear all slots, valid bits and both counters to 0; o_insn_vld = 0.
REQ-031 SHALL, during reset, present o_pc_en = 1, o_ifid_en = 1, all flushes 0 and o_pc_sel = 0 when i_id_vld = 0.
REQ-032 SHALL, on reset asserted mid-stall, release the stall immediately with no residual bubbles after deassertion.

Verification
REQ-033 SHALL pass: addi x5 issued, then add x6,x5,x0 in the next cycle -> 2 stall cycles, o_stall_cnt = 2, o_insn_vld pulses for both instructions.
REQ-034 SHALL pass: one independent instruction between producer x7 and consumer x7 -> exactly 1 stall cycle; with WB_BYPASS = 0 -> 2 stall cycles.
REQ-035 SHALL pass: consumer reads x0 after producer writes x0 -> 0 stalls.
REQ-036 SHALL pass: i_ex_redirect = 1 while hazard = 1 -> o_pc_sel = 1, both flushes = 1, o_flush_cnt += 1, o_stall_cnt unchanged.
REQ-037 SHALL pass: reset pulsed during the 2nd stall cycle -> slots cleared, o_stall_cnt = 0, the next ID instruction issues without stall.
REQ-038 SHALL pass: o_stall_cnt preloaded via hierarchical force to 0xFFFFFFFF plus one stall -> 0x00000000.
